// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add multiplier: one WIDTH-bit ripple-carry adder reused over
// WIDTH iterations, with a start/done handshake and an IDLE/RUN/DONE control FSM.
module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  // Handshake: start is accepted on a rising edge only while ready=1; a and b are
  // captured on that same edge. done is a one-cycle pulse, and product stays valid
  // from that pulse until the next operation completes.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  m, acc, q;
  logic              c;
  logic [CW-1:0]     count;
  logic              last_iter;
  logic [WIDTH-1:0]  addend, sum;
  logic [WIDTH:0]    cy;

  assign last_iter = (count == CW'(WIDTH - 1));
  assign addend    = q[0] ? m : '0;
  assign dbg_state = state;

  // Ripple-carry adder made of per-bit full adders. c is always 0 at the start of
  // an iteration, because the shift moves the carry into acc, so the adder's
  // carry-in is effectively 0.
  assign cy[0] = c;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = acc[i] ^ addend[i] ^ cy[i];
    assign cy[i+1] = (acc[i] & addend[i]) | (cy[i] & (acc[i] ^ addend[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // {c, acc, q} <= {carry, sum, q} >> 1 keeps the adder carry as the new acc MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      c       <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            c     <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          c     <= 1'b0;
          acc   <= {cy[WIDTH], sum[WIDTH-1:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          count <= count + CW'(1);
          if (last_iter) product <= {cy[WIDTH], sum, q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: timeline model plus per-cycle compare,
// with directed vectors and literal expectations for WIDTH=4 and WIDTH=8 builds.
module tb_seq_mult_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         ready, busy, done;
  logic [2*W-1:0] product;
  logic [1:0]   dbg_state;

  logic         start8;
  logic [7:0]   a8, b8;
  logic         ready8, busy8, done8;
  logic [15:0]  product8;
  logic [1:0]   dbg_state8;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product),
    .dbg_state(dbg_state)
  );

  seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8),
    .dbg_state(dbg_state8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Timeline model: an accepted operation is busy for W cycles, done in the next
  // one, then idle; product becomes a*b with the done cycle and holds otherwise.
  int           m_since = -1;
  bit           m_valid = 1'b0;
  logic [2*W-1:0] m_op   = '0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] exp_q[$];
  int           m_accepts = 0;
  int           n_dones   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_since = -1;
      m_prod  = '0;
      m_valid = 1'b1;
      exp_q.delete();
    end else if (m_valid) begin
      if (m_since < 0) begin
        if (start) begin
          m_op    = (2*W)'(a) * (2*W)'(b);
          m_since = 0;
          m_accepts++;
          exp_q.push_back(m_op);
        end
      end else if (m_since == W) begin
        m_since = -1;
      end else begin
        m_since++;
        if (m_since == W) m_prod = m_op;
      end
    end
  end

  // scoreboard / compare process
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready",   32'(ready),   32'(m_since < 0));
      chk("busy",    32'(busy),    32'(m_since >= 0 && m_since < W));
      chk("done",    32'(done),    32'(m_since == W));
      chk("product", 32'(product), 32'(m_prod));
      if (done) begin
        n_dones++;
        if (exp_q.size() > 0) chk("done_product", 32'(product), 32'(exp_q.pop_front()));
        else chk("unexpected_done", 32'd1, 32'd0);
      end
    end
  end

  // driver tasks
  int last_acc = -1;

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input bit scramble, input bit chk_gap);
    int k;
    @(negedge clk);
    k = 0;
    while (!ready && k < 50) begin
      if (scramble) begin
        a = W'(k * 5 + 3);
        b = W'(k * 7 + 1);
      end
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    if (chk_gap && last_acc >= 0) chk("accept_gap", 32'(cyc - last_acc), 32'(W + 2));
    last_acc = cyc;
    a     = ai;
    b     = bi;
    start = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_done(input bit drop_start, output int n, output int busy_n,
                           output bit ready_after1);
    n = 0;
    busy_n = 0;
    ready_after1 = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) ready_after1 = ready;
      if (busy) busy_n++;
      if (drop_start) start = 1'b0;
    end while (!done && n < 50);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int n, busy_n;
  bit r1;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",   32'(ready),   32'd1);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_product", 32'(product), 32'h0);
    rst = 1'b0;

    // 15*15: exercises carry preservation and the full timeline
    issue(4'd15, 4'd15, 1'b0, 1'b0);
    wait_done(1'b1, n, busy_n, r1);
    chk("t1_ready_drop",  32'(r1),      32'd0);
    chk("t1_busy_cycles", 32'(busy_n),  32'd4);
    chk("t1_done_cycle",  32'(n),       32'd5);
    chk("t1_product",     32'(product), 32'hE1);
    @(negedge clk);
    chk("t1_ready_back",  32'(ready),   32'd1);
    chk("t1_done_pulse",  32'(done),    32'd0);

    // operand corners
    issue(4'd0, 4'd9, 1'b0, 1'b0);  wait_done(1'b1, n, busy_n, r1);
    chk("c_0x9",  32'(product), 32'h00);
    issue(4'd1, 4'd1, 1'b0, 1'b0);  wait_done(1'b1, n, busy_n, r1);
    chk("c_1x1",  32'(product), 32'h01);
    issue(4'd10, 4'd6, 1'b0, 1'b0); wait_done(1'b1, n, busy_n, r1);
    chk("c_10x6", 32'(product), 32'h3C);
    issue(4'd8, 4'd8, 1'b0, 1'b0);  wait_done(1'b1, n, busy_n, r1);
    chk("c_8x8",  32'(product), 32'h40);

    // start held high, operands scrambled while the block is not ready
    last_acc = -1;
    issue(4'd7, 4'd9, 1'b1, 1'b1);
    issue(4'd12, 4'd5, 1'b1, 1'b1);
    issue(4'd3, 4'd14, 1'b1, 1'b1);
    wait_done(1'b0, n, busy_n, r1);
    chk("hold_last_product", 32'(product), 32'd42);

    // exhaustive 4x4, back-to-back
    for (int i = 0; i < 256; i++)
      issue(W'(i >> 4), W'(i & 15), 1'b0, 1'b1);
    wait_done(1'b1, n, busy_n, r1);
    chk("exh_last_product", 32'(product), 32'd225);
    repeat (2) @(negedge clk);
    chk("done_per_start", 32'(n_dones), 32'(m_accepts));

    // reset on the second RUN iteration of 13*11
    issue(4'd13, 4'd11, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_ready",   32'(ready),   32'd1);
    chk("abort_busy",    32'(busy),    32'd0);
    chk("abort_done",    32'(done),    32'd0);
    chk("abort_product", 32'(product), 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(n_dones), 32'(m_accepts - 1));
    issue(4'd13, 4'd11, 1'b0, 1'b0);
    wait_done(1'b1, n, busy_n, r1);
    chk("retry_product", 32'(product), 32'h8F);
    chk("retry_cycle",   32'(n),       32'd5);

    // WIDTH=8 build
    @(negedge clk);
    chk("w8_ready", 32'(ready8), 32'd1);
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start8 = 1'b0;
      a8 = 8'(n); b8 = 8'(n * 3);
    end while (!done8 && n < 50);
    chk("w8_done_cycle", 32'(n),        32'd9);
    chk("w8_product",    32'(product8), 32'hFE01);
    chk("w8_busy_end",   32'(busy8),    32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
